arbitro_memoria_dados: RTL and testbench
========================================

Name: arbitro_memoria_dados

Overview:
- Round-robin arbiter that shares the single-port 8-bit, 256-entry data memory between two requesters.
  - Requester 0: processor datapath.
  - Requester 1: loader/debug port.
- Sits between both requesters and the data memory, and owns the memory's EscMem, LerMem, Endereco and DadoEscritoMem inputs.
- Drives one access at a time, respects the memory's posedge-write / negedge-read timing, and returns an acknowledge plus the read data to the winner.

Parameters:
- LARGURA_DADO, 8, data width (matches the memory word).
- LARGURA_END, 8, address width (256 words).
- LARGURA_CONT, 8, width of the saturating conflict counter.

Ports:
- Clock  input  1  system clock, rising-edge active.
- Reset  input  1  synchronous, active-high reset.
- Req0  input  1  requester 0 access request; held until Ack0.
- Esc0  input  1  requester 0: 1=write, 0=read; valid while Req0.
- End0  input  LARGURA_END  requester 0 address.
- Dado0  input  LARGURA_DADO  requester 0 write data.
- Ack0  output  1  one-cycle completion pulse to requester 0.
- Lido0  output  LARGURA_DADO  read data to requester 0; valid when Ack0=1 on a read.
- Req1, Esc1, End1, Dado1, Ack1, Lido1: same as above, for requester 1.
- MemEndereco  output  LARGURA_END  to memory Endereco.
- MemDadoEscrito  output  LARGURA_DADO  to memory DadoEscritoMem.
- MemEscMem  output  1  to memory EscMem.
- MemLerMem  output  1  to memory LerMem.
- DadoLidoMem  input  LARGURA_DADO  from memory read port.
- Ocupado  output  1  high while state != OCIOSO.
- Conflitos  output  LARGURA_CONT  count of grants made while both Req were high.

Behaviour:
- All outputs are registered. Clock and reset are as stated in Ports.
- Reset values:
  - State OCIOSO.
  - Ack0/Ack1, MemEscMem, MemLerMem, Ocupado = 0.
  - Lido0, Lido1, MemEndereco, MemDadoEscrito, Conflitos = 0.
  - Ultimo (last served) = 1, so requester 0 wins the first tie.
- States: OCIOSO, ACESSO, CONCLUI.
- OCIOSO:
  - No Req: stay.
  - Otherwise choose the winner W:
    - only one Req high: that requester;
    - both high: !Ultimo.
  - On posedge k, latch End_W into MemEndereco and Dado_W into MemDadoEscrito.
  - Set MemEscMem=Esc_W and MemLerMem=!Esc_W; set Ultimo=W; go to ACESSO.
  - If both Req were high, increment Conflitos, saturating at all-ones (no wrap).
- ACESSO (cycle k..k+1):
  - The memory reads at the negedge inside this cycle, or writes at posedge k+1.
  - At posedge k+1:
    - clear MemEscMem and MemLerMem;
    - on a read, capture DadoLidoMem into Lido_W;
    - set Ack_W=1;
    - go to CONCLUI.
- CONCLUI (cycle k+1..k+2):
  - Ack_W is high for exactly this cycle.
  - At posedge k+2: Ack_W=0; go to OCIOSO.
  - The requester must drop Req in this cycle. A Req still high at posedge k+2 is treated as a new request.
- Latency:
  - Req sampled at edge k gives Ack high in cycle k+1..k+2; 2 cycles per access.
  - Back-to-back accesses run at 3 cycles each (OCIOSO → ACESSO → CONCLUI).
- Lido_W holds its value until the next read by the same requester. The non-winner's Ack and Lido are unchanged.
- Requests arriving in ACESSO or CONCLUI wait; nothing is dropped while Req is held.
- End/Dado/Esc changes after the grant edge are ignored, because the latched copy is used.
- Starvation freedom: with both Req continuously high, grants strictly alternate 0,1,0,1.
- Reset mid-operation:
  - The state returns to OCIOSO on that edge and all memory controls drop to 0 after it.
  - A write whose MemEscMem was high at the reset edge still completes in memory, since the memory samples the same edge. This is accepted.
  - No Ack is issued for an aborted access.
- MemEscMem and MemLerMem are never simultaneously 1.

Decomposition:
- Shared package/header (defines include): state encodings (OCIOSO=2'd0, ACESSO=2'd1, CONCLUI=2'd2) and the default widths.
- Sub-module escolha_rr: combinational round-robin pick.
  - Inputs: Req0, Req1, Ultimo.
  - Outputs: Concede, W, Conflito.
- The FSM and registers stay in the top module.

Test Plan:
- Write then read, requester 0: Req0=1, Esc0=1, End0=8'h10, Dado0=8'hA5 → Ack0 at k+1, mem[16]=A5. Then a read of 8'h10 → Lido0=8'hA5 with Ack0, MemLerMem pulsed once.
- Simultaneous: Req0 and Req1 rise together after reset (reads of 8'h01 and 8'h02) → requester 0 served first, then requester 1; Conflitos=1.
- Fairness: both Req held high for 4 accesses → Ack order 0,1,0,1, Conflitos=4.
- Saturation: 260 forced conflicts → Conflitos stays 8'hFF.
- Reset in ACESSO during a read of requester 1 → next cycle state OCIOSO, MemLerMem=0, Ack1 never pulses, Lido1 unchanged from its reset value 0.
- Held Req after Ack: Req0 kept high through CONCLUI → second access granted, Ack0 pulses again 3 cycles later; address latched at the grant, not changed by End0 toggling afterwards.

Source files
------------

// File: rtl/arbitro_memoria_dados_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding and default widths.
package arbitro_memoria_dados_pkg;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        ACESSO  = 2'd1,
        CONCLUI = 2'd2
    } estado_t;

    localparam int LARGURA_DADO_PADRAO = 8;
    localparam int LARGURA_END_PADRAO  = 8;
    localparam int LARGURA_CONT_PADRAO = 8;

endpackage

// File: rtl/arbitro_memoria_dados_escolha_rr.sv
// Combinational round-robin pick between two requesters.
module arbitro_memoria_dados_escolha_rr (
    input  logic Req0,
    input  logic Req1,
    input  logic Ultimo,
    output logic Concede,
    output logic W,
    output logic Conflito
);

    always_comb begin
        Concede  = Req0 | Req1;
        Conflito = Req0 & Req1;
        // On a tie the requester not served last wins; otherwise whoever asks.
        W        = Conflito ? ~Ultimo : Req1;
    end

endmodule

// File: rtl/arbitro_memoria_dados.sv
// Two-requester round-robin arbiter in front of the single-port 256x8 data memory.
// Handshake: a requester raises Req with Esc/End/Dado valid and holds it until its
// one-cycle Ack pulse; on a read Lido is valid with Ack. Req still high after the
// Ack cycle is taken as a new request.
module arbitro_memoria_dados
    import arbitro_memoria_dados_pkg::*;
#(
    parameter int LARGURA_DADO = LARGURA_DADO_PADRAO,
    parameter int LARGURA_END  = LARGURA_END_PADRAO,
    parameter int LARGURA_CONT = LARGURA_CONT_PADRAO
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    Req0,
    input  logic                    Esc0,
    input  logic [LARGURA_END-1:0]  End0,
    input  logic [LARGURA_DADO-1:0] Dado0,
    output logic                    Ack0,
    output logic [LARGURA_DADO-1:0] Lido0,
    input  logic                    Req1,
    input  logic                    Esc1,
    input  logic [LARGURA_END-1:0]  End1,
    input  logic [LARGURA_DADO-1:0] Dado1,
    output logic                    Ack1,
    output logic [LARGURA_DADO-1:0] Lido1,
    output logic [LARGURA_END-1:0]  MemEndereco,
    output logic [LARGURA_DADO-1:0] MemDadoEscrito,
    output logic                    MemEscMem,
    output logic                    MemLerMem,
    input  logic [LARGURA_DADO-1:0] DadoLidoMem,
    output logic                    Ocupado,
    output logic [LARGURA_CONT-1:0] Conflitos,
    output logic [1:0]              Estado
);

    estado_t estado;
    logic    ultimo;
    logic    concede;
    logic    w;
    logic    conflito;
    logic    esc_w;

    arbitro_memoria_dados_escolha_rr u_escolha (
        .Req0     (Req0),
        .Req1     (Req1),
        .Ultimo   (ultimo),
        .Concede  (concede),
        .W        (w),
        .Conflito (conflito)
    );

    assign esc_w  = w ? Esc1 : Esc0;
    assign Estado = estado;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            estado         <= OCIOSO;
            ultimo         <= 1'b1;
            Ack0           <= 1'b0;
            Ack1           <= 1'b0;
            Lido0          <= '0;
            Lido1          <= '0;
            MemEndereco    <= '0;
            MemDadoEscrito <= '0;
            MemEscMem      <= 1'b0;
            MemLerMem      <= 1'b0;
            Ocupado        <= 1'b0;
            Conflitos      <= '0;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (concede) begin
                        MemEndereco    <= w ? End1 : End0;
                        MemDadoEscrito <= w ? Dado1 : Dado0;
                        MemEscMem      <= esc_w;
                        MemLerMem      <= ~esc_w;
                        ultimo         <= w;
                        Ocupado        <= 1'b1;
                        estado         <= ACESSO;
                        if (conflito && (Conflitos != '1))
                            Conflitos <= Conflitos + LARGURA_CONT'(1);
                    end
                end
                ACESSO: begin
                    // Memory has read at the negedge or writes on this edge.
                    MemEscMem <= 1'b0;
                    MemLerMem <= 1'b0;
                    if (ultimo) begin
                        Ack1 <= 1'b1;
                        if (MemLerMem)
                            Lido1 <= DadoLidoMem;
                    end else begin
                        Ack0 <= 1'b1;
                        if (MemLerMem)
                            Lido0 <= DadoLidoMem;
                    end
                    estado <= CONCLUI;
                end
                CONCLUI: begin
                    Ack0    <= 1'b0;
                    Ack1    <= 1'b0;
                    Ocupado <= 1'b0;
                    estado  <= OCIOSO;
                end
                default: begin
                    Ack0      <= 1'b0;
                    Ack1      <= 1'b0;
                    MemEscMem <= 1'b0;
                    MemLerMem <= 1'b0;
                    Ocupado   <= 1'b0;
                    estado    <= OCIOSO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arbitro_memoria_dados.sv
// Bench for the data-memory arbiter: behavioural memory, ack scoreboard, vector table and corner sequences.
module tb_arbitro_memoria_dados;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       Req0 = 1'b0, Esc0 = 1'b0, Req1 = 1'b0, Esc1 = 1'b0;
    logic [7:0] End0 = '0, Dado0 = '0, End1 = '0, Dado1 = '0;
    logic       Ack0, Ack1, MemEscMem, MemLerMem, Ocupado;
    logic [7:0] Lido0, Lido1, MemEndereco, MemDadoEscrito, Conflitos;
    logic [7:0] DadoLidoMem = '0;
    logic [1:0] Estado;

    int n_tests = 0;
    int n_fail  = 0;
    int excl_viol = 0;
    int le_pulsos = 0;
    int es_pulsos = 0;

    // {id, is_read, data}
    logic [9:0] exp_q[$];
    logic [7:0] lido_exp[2];
    logic [7:0] mem[256];
    bit         mem_pronta = 1'b0;
    int         ordem[300];

    typedef struct {
        logic       id;
        logic       esc;
        logic [7:0] ender;
        logic [7:0] dado;
        logic [7:0] exp_lido;
    } vetor_t;
    vetor_t tabela[10];

    arbitro_memoria_dados dut (
        .Clock(Clock), .Reset(Reset),
        .Req0(Req0), .Esc0(Esc0), .End0(End0), .Dado0(Dado0), .Ack0(Ack0), .Lido0(Lido0),
        .Req1(Req1), .Esc1(Esc1), .End1(End1), .Dado1(Dado1), .Ack1(Ack1), .Lido1(Lido1),
        .MemEndereco(MemEndereco), .MemDadoEscrito(MemDadoEscrito),
        .MemEscMem(MemEscMem), .MemLerMem(MemLerMem), .DadoLidoMem(DadoLidoMem),
        .Ocupado(Ocupado), .Conflitos(Conflitos), .Estado(Estado)
    );

    // ---------------- clock / reset ----------------
    always #5 Clock = ~Clock;

    task automatic aplica_reset();
        Reset = 1'b1;
        repeat (2) @(posedge Clock);
        #1 Reset = 1'b0;
    endtask

    // ---------------- memory model ----------------
    always @(posedge Clock) begin
        if (!mem_pronta) begin
            for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
            mem_pronta = 1'b1;
        end else if (MemEscMem) begin
            mem[MemEndereco] = MemDadoEscrito;
        end
    end

    always @(negedge Clock) begin
        if (MemLerMem) DadoLidoMem = mem[MemEndereco];
        if (MemLerMem) le_pulsos++;
        if (MemEscMem) es_pulsos++;
        if (MemEscMem && MemLerMem) excl_viol++;
    end

    // ---------------- checking ----------------
    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        n_tests++;
        if (atual !== esperado) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nome, atual, esperado, $time);
        end
    endtask

    // Scoreboard: every Ack pops one expected entry.
    always @(negedge Clock) begin
        if (Reset) begin
            lido_exp[0] = '0;
            lido_exp[1] = '0;
        end else if (Ack0 || Ack1) begin
            logic       id;
            logic [9:0] e;
            id = Ack1;
            if (Ack0 && Ack1) check("ack_unico", 1, 0);
            if (exp_q.size() == 0) begin
                check("ack_inesperado", {31'd0, id}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("sb_id", {31'd0, id}, {31'd0, e[9]});
                if (e[8]) lido_exp[id] = e[7:0];
                check("sb_lido", id ? Lido1 : Lido0, lido_exp[id]);
                check("sb_lido_outro", id ? Lido0 : Lido1, lido_exp[!id]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_ack(input logic id, input int limite, output int n);
        n = -1;
        for (int i = 1; i <= limite; i++) begin
            @(negedge Clock);
            if (id ? Ack1 : Ack0) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic acesso_unico(input vetor_t v);
        int n;
        @(posedge Clock);
        #1;
        le_pulsos = 0;
        es_pulsos = 0;
        exp_q.push_back({v.id, ~v.esc, v.esc ? 8'h00 : v.exp_lido});
        if (v.id) begin
            Req1 = 1'b1; Esc1 = v.esc; End1 = v.ender; Dado1 = v.dado;
        end else begin
            Req0 = 1'b1; Esc0 = v.esc; End0 = v.ender; Dado0 = v.dado;
        end
        wait_ack(v.id, 10, n);
        Req0 = 1'b0;
        Req1 = 1'b0;
        check("latencia", n, 3);
        check("ocupado_conclui", {31'd0, Ocupado}, 1);
        check("pulsos_ler", le_pulsos, v.esc ? 0 : 1);
        check("pulsos_esc", es_pulsos, v.esc ? 1 : 0);
        if (v.esc) check("mem_escrita", mem[v.ender], v.dado);
        @(negedge Clock);
        check("estado_ocioso", {30'd0, Estado}, 0);
        check("ocupado_zero", {31'd0, Ocupado}, 0);
    endtask

    // Serve both requesters; hold both Req until 'total' acks, or drop each on its own ack.
    task automatic serve_ambos(input int total, input bit solta_cada, output int n_ack);
        n_ack = 0;
        for (int c = 0; c < total * 3 + 20 && n_ack < total; c++) begin
            @(negedge Clock);
            if (Ack0) begin ordem[n_ack] = 0; n_ack++; if (solta_cada) Req0 = 1'b0; end
            if (Ack1) begin ordem[n_ack] = 1; n_ack++; if (solta_cada) Req1 = 1'b0; end
        end
        Req0 = 1'b0;
        Req1 = 1'b0;
        check("acks_total", n_ack, total);
    endtask

    // ---------------- test ----------------
    initial begin
        int n;
        int n_ack;
        int erros;

        tabela[0] = '{1'b0, 1'b1, 8'h10, 8'hA5, 8'h00};
        tabela[1] = '{1'b0, 1'b0, 8'h10, 8'h00, 8'hA5};
        tabela[2] = '{1'b1, 1'b1, 8'h20, 8'h3C, 8'h00};
        tabela[3] = '{1'b1, 1'b0, 8'h20, 8'h00, 8'h3C};
        tabela[4] = '{1'b1, 1'b0, 8'h10, 8'h00, 8'hA5};
        tabela[5] = '{1'b0, 1'b0, 8'h20, 8'h00, 8'h3C};
        tabela[6] = '{1'b0, 1'b0, 8'h7E, 8'h00, 8'h24};
        tabela[7] = '{1'b1, 1'b1, 8'h00, 8'hFF, 8'h00};
        tabela[8] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'hFF};
        tabela[9] = '{1'b0, 1'b0, 8'h03, 8'h00, 8'h59};

        aplica_reset();
        @(negedge Clock);
        check("rst_estado", {30'd0, Estado}, 0);
        check("rst_acks", {30'd0, Ack1, Ack0}, 0);
        check("rst_memctl", {30'd0, MemEscMem, MemLerMem}, 0);
        check("rst_ocupado", {31'd0, Ocupado}, 0);
        check("rst_lidos", {16'd0, Lido1, Lido0}, 0);
        check("rst_mem_end_dado", {16'd0, MemEndereco, MemDadoEscrito}, 0);
        check("rst_conflitos", Conflitos, 0);

        for (int i = 0; i < 10; i++) acesso_unico(tabela[i]);
        check("conflitos_sem_disputa", Conflitos, 0);
        check("fila_vazia_tabela", exp_q.size(), 0);

        // Simultaneous reads right after reset: requester 0 first.
        aplica_reset();
        @(posedge Clock); #1;
        exp_q.push_back({1'b0, 1'b1, 8'h5B});
        exp_q.push_back({1'b1, 1'b1, 8'h58});
        Req0 = 1'b1; Esc0 = 1'b0; End0 = 8'h01;
        Req1 = 1'b1; Esc1 = 1'b0; End1 = 8'h02;
        serve_ambos(2, 1'b1, n_ack);
        check("simult_ordem", {ordem[0][15:0], ordem[1][15:0]}, {16'd0, 16'd1});
        check("simult_conflitos", Conflitos, 1);
        repeat (2) @(negedge Clock);
        check("fila_vazia_simult", exp_q.size(), 0);

        // Fairness: both held for four accesses.
        aplica_reset();
        @(posedge Clock); #1;
        for (int i = 0; i < 4; i++) exp_q.push_back({i[0], 1'b1, i[0] ? 8'h6B : 8'h6A});
        Req0 = 1'b1; Esc0 = 1'b0; End0 = 8'h30;
        Req1 = 1'b1; Esc1 = 1'b0; End1 = 8'h31;
        serve_ambos(4, 1'b0, n_ack);
        check("justica_ordem", {ordem[0][7:0], ordem[1][7:0], ordem[2][7:0], ordem[3][7:0]}, 32'h00010001);
        check("justica_conflitos", Conflitos, 4);
        repeat (2) @(negedge Clock);
        check("fila_vazia_justica", exp_q.size(), 0);

        // Saturation: 260 conflicting writes.
        aplica_reset();
        @(posedge Clock); #1;
        for (int i = 0; i < 260; i++) exp_q.push_back({i[0], 1'b0, 8'h00});
        Req0 = 1'b1; Esc0 = 1'b1; End0 = 8'h40; Dado0 = 8'h11;
        Req1 = 1'b1; Esc1 = 1'b1; End1 = 8'h41; Dado1 = 8'h22;
        serve_ambos(260, 1'b0, n_ack);
        erros = 0;
        for (int i = 0; i < n_ack; i++) if (ordem[i] != (i % 2)) erros++;
        check("saturacao_alterna", erros, 0);
        check("saturacao_conflitos", Conflitos, 8'hFF);
        check("saturacao_mem", {mem[8'h40], mem[8'h41]}, 16'h1122);
        repeat (2) @(negedge Clock);
        check("fila_vazia_saturacao", exp_q.size(), 0);

        // Reset while requester 1 read is in ACESSO.
        aplica_reset();
        @(posedge Clock); #1;
        Req1 = 1'b1; Esc1 = 1'b0; End1 = 8'h20;
        repeat (2) @(negedge Clock);
        check("abort_em_acesso", {30'd0, Estado}, 1);
        check("abort_ler_alto", {31'd0, MemLerMem}, 1);
        Reset = 1'b1;
        Req1  = 1'b0;
        @(negedge Clock);
        check("abort_estado", {30'd0, Estado}, 0);
        check("abort_ler_baixo", {31'd0, MemLerMem}, 0);
        check("abort_ocupado", {31'd0, Ocupado}, 0);
        Reset = 1'b0;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clock);
            if (Ack1) n++;
        end
        check("abort_sem_ack", n, 0);
        check("abort_lido1", Lido1, 0);

        // Held Req0: second access three cycles later, address latched at grant.
        aplica_reset();
        @(posedge Clock); #1;
        exp_q.push_back({1'b0, 1'b1, 8'hA5});
        exp_q.push_back({1'b0, 1'b1, 8'hA5});
        Req0 = 1'b1; Esc0 = 1'b0; End0 = 8'h10;
        wait_ack(1'b0, 10, n);
        check("mantido_lat1", n, 3);
        n = -1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge Clock);
            if (k == 2) begin
                check("mantido_acesso", {30'd0, Estado}, 1);
                check("mantido_end", MemEndereco, 8'h10);
                End0 = 8'h20;
            end
            if (Ack0) begin
                n = k;
                break;
            end
        end
        Req0 = 1'b0;
        check("mantido_lat2", n, 3);
        check("mantido_lido", Lido0, 8'hA5);
        repeat (2) @(negedge Clock);
        check("fila_vazia_mantido", exp_q.size(), 0);
        check("exclusao_esc_ler", excl_viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
